stopwatch_chain: RTL and testbench

Parametrised, single-clock successor to the stopwatch digit counters. A chain of NUM_DIGITS modulo digits with per-digit maximum values advances on a prescaled time-base tick. It adds count-down (timer) mode, preload, lap freeze and wrap/done events. It sits between the tick prescaler and the 7-segment display mux. Carries ripple combinationally within one cycle, and no derived clocks are used.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/mod_digit_cell.sv | 49 ++++
 rtl/stopwatch_chain.sv | 140 ++++++++++++++
 tb/tb_stopwatch_chain.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch digit chain.
//   sw_state_t          : chain FSM state encoding
//   SW_DEFAULT_MAX_VEC  : default packed per-digit maxima (9,9,5,9 from digit 0 up)
//   digit_max()         : extract one digit maximum from a packed maximum vector
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_STOPPED = 2'd0,
    SW_RUNNING = 2'd1,
    SW_EXPIRED = 2'd2
  } sw_state_t;

  localparam logic [15:0] SW_DEFAULT_MAX_VEC = 16'h9599;

  // Returns field idx of width w from a packed vector (zero-extended to 32 bits).
  function automatic logic [31:0] digit_max(input logic [255:0] vec,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return 32'(vec >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/mod_digit_cell.sv
// One modulo digit of the stopwatch chain.
//   mclock     : clock
//   clear      : synchronous active-high reset
//   enable     : advance this digit this cycle (tick or ripple from lower digit)
//   dir        : 0 = up, 1 = down
//   load       : preload from load_val (saturated to max_val); beats enable
//   load_val   : preload digit value
//   max_val    : digit maximum (modulus - 1)
//   value      : registered digit value
//   carry_out  : enable & up & at maximum (combinational)
//   borrow_out : enable & down & at zero (combinational)
module mod_digit_cell #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               mclock,
  input  logic               clear,
  input  logic               enable,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out,
  output logic               borrow_out
);

  logic               at_max;
  logic               at_zero;
  logic [DIGIT_W-1:0] load_sat;

  assign at_max     = (value == max_val);
  assign at_zero    = (value == '0);
  assign load_sat   = (load_val > max_val) ? max_val : load_val;
  assign carry_out  = enable & ~dir & at_max;
  assign borrow_out = enable &  dir & at_zero;

  // Digit register: clear > load > count.
  always_ff @(posedge mclock) begin
    if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_sat;
    end else if (enable) begin
      if (!dir) value <= at_max  ? '0      : value + DIGIT_W'(1);
      else      value <= at_zero ? max_val : value - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_chain.sv
// Stopwatch / timer digit chain with preload, lap freeze and wrap/done events.
//   mclock, clear        : clock, synchronous active-high reset
//   tick                 : time-base enable pulse
//   start_stop           : toggles STOPPED <-> RUNNING (ignored in EXPIRED)
//   mode                 : 0 = count up, 1 = count down
//   load, load_val       : preload (digits saturated to their maxima)
//   lap                  : toggles the display freeze
//   count                : live chain value
//   digits               : frozen snapshot while lap_active, else count (combinational)
//   running, lap_active  : status
//   wrap, done           : one-cycle event pulses (up wrap, down reached zero)
module stopwatch_chain
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MAX_VEC =
    (NUM_DIGITS*DIGIT_W)'(SW_DEFAULT_MAX_VEC)
) (
  input  logic                          mclock,
  input  logic                          clear,
  input  logic                          tick,
  input  logic                          start_stop,
  input  logic                          mode,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  input  logic                          lap,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          running,
  output logic                          lap_active,
  output logic                          wrap,
  output logic                          done
);

  localparam int unsigned CHAIN_W = NUM_DIGITS * DIGIT_W;

  sw_state_t state, state_n;

  logic [NUM_DIGITS-1:0] en;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] borrow;
  logic [CHAIN_W-1:0]    snapshot;
  logic                  run_tick;
  logic                  count_zero;
  logic                  count_one;
  logic                  wrap_c;
  logic                  done_c;
  logic                  unused_borrow;

  // A tick counts only while running and not pre-empted by load.
  assign run_tick   = (state == SW_RUNNING) & tick & ~load;
  assign count_zero = (count == '0);
  assign count_one  = (count == CHAIN_W'(1));

  // Down count from all-zero holds at zero instead of underflowing.
  assign en[0]  = run_tick & ~(mode & count_zero);
  assign wrap_c = run_tick & ~mode & carry[NUM_DIGITS-1];
  assign done_c = run_tick &  mode & (count_zero | count_one);

  // The top digit can never borrow: that would need an all-zero chain, which is gated off.
  assign unused_borrow = borrow[NUM_DIGITS-1];

  // Digit chain with combinational carry/borrow ripple.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam logic [DIGIT_W-1:0] DMAX =
      DIGIT_W'(digit_max(256'(MAX_VEC), gi, DIGIT_W));

    mod_digit_cell #(.DIGIT_W(DIGIT_W)) u_cell (
      .mclock     (mclock),
      .clear      (clear),
      .enable     (en[gi]),
      .dir        (mode),
      .load       (load),
      .load_val   (load_val[gi*DIGIT_W +: DIGIT_W]),
      .max_val    (DMAX),
      .value      (count[gi*DIGIT_W +: DIGIT_W]),
      .carry_out  (carry[gi]),
      .borrow_out (borrow[gi])
    );

    if (gi < NUM_DIGITS - 1) begin : g_ripple
      assign en[gi+1] = carry[gi] | borrow[gi];
    end
  end

  // FSM state register; running is registered from the next state.
  always_ff @(posedge mclock) begin
    if (clear) begin
      state   <= SW_STOPPED;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == SW_RUNNING);
    end
  end

  // FSM next state; expiry wins over a simultaneous start_stop.
  always_comb begin
    state_n = state;
    case (state)
      SW_STOPPED: if (start_stop) state_n = SW_RUNNING;
      SW_RUNNING: begin
        if (done_c)          state_n = SW_EXPIRED;
        else if (start_stop) state_n = SW_STOPPED;
      end
      SW_EXPIRED: if (load) state_n = SW_STOPPED;
      default:    state_n = SW_STOPPED;
    endcase
  end

  // Event pulses, registered so they line up with the updated count.
  always_ff @(posedge mclock) begin
    if (clear) begin
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      wrap <= wrap_c;
      done <= done_c;
    end
  end

  // Lap freeze: capture the pre-update count on entry, release on the next pulse.
  always_ff @(posedge mclock) begin
    if (clear) begin
      lap_active <= 1'b0;
      snapshot   <= '0;
    end else if (lap) begin
      if (!lap_active) begin
        snapshot   <= count;
        lap_active <= 1'b1;
      end else begin
        lap_active <= 1'b0;
      end
    end
  end

  assign digits = lap_active ? snapshot : count;

endmodule

// File: tb/tb_stopwatch_chain.sv
// Directed scoreboard bench for stopwatch_chain (default 4 x 4-bit digits, max 9,9,5,9).
module tb_stopwatch_chain;

  localparam logic [15:0] MAXV = 16'h9599;

  logic        mclock = 1'b0;
  logic        clear, tick, start_stop, mode, load, lap;
  logic [15:0] load_val;
  logic [15:0] count, digits;
  logic        running, lap_active, wrap, done;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic [15:0] dig;
    logic        run;
    logic        lapa;
    logic        wr;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  stopwatch_chain dut (
    .mclock     (mclock),
    .clear      (clear),
    .tick       (tick),
    .start_stop (start_stop),
    .mode       (mode),
    .load       (load),
    .load_val   (load_val),
    .lap        (lap),
    .count      (count),
    .digits     (digits),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap),
    .done       (done)
  );

  always #5 mclock = ~mclock;

  // Mixed-radix reference: integer n expressed in the chain's digit moduli.
  function automatic logic [15:0] chain_of(input int n);
    logic [15:0] r;
    int rem;
    int m;
    r   = '0;
    rem = n;
    for (int i = 0; i < 4; i++) begin
      m = int'((MAXV >> (i * 4)) & 16'h000F) + 1;
      r[i*4 +: 4] = 4'(rem % m);
      rem = rem / m;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [15:0] cnt, input logic [15:0] dig,
                          input logic run, input logic lapa, input logic wr, input logic dn);
    exp_t e;
    e.tag = tag; e.cnt = cnt; e.dig = dig; e.run = run; e.lapa = lapa; e.wr = wr; e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".count"},      count,             e.cnt);
      chk({e.tag, ".digits"},     digits,            e.dig);
      chk({e.tag, ".running"},    16'(running),      16'(e.run));
      chk({e.tag, ".lap_active"}, 16'(lap_active),   16'(e.lapa));
      chk({e.tag, ".wrap"},       16'(wrap),         16'(e.wr));
      chk({e.tag, ".done"},       16'(done),         16'(e.dn));
    end
  endtask

  // One clock; pulse inputs return low just after the edge.
  task automatic cyc();
    @(posedge mclock);
    #1;
    clear = 0; tick = 0; start_stop = 0; load = 0; lap = 0;
  endtask

  task automatic step(input string tag, input logic [15:0] cnt, input logic [15:0] dig,
                      input logic run, input logic lapa, input logic wr, input logic dn);
    push_exp(tag, cnt, dig, run, lapa, wr, dn);
    cyc();
    check_out();
  endtask

  initial begin
    clear = 1; tick = 0; start_stop = 0; mode = 0; load = 0; lap = 0; load_val = '0;
    @(negedge mclock);

    // Reset state
    clear = 1;
    step("reset", 16'h0000, 16'h0000, 0, 0, 0, 0);

    // Up count, 100 ticks
    start_stop = 1;
    step("t1_start", 16'h0000, 16'h0000, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      tick = 1;
      cyc();
    end
    push_exp("t1_100ticks", chain_of(100), chain_of(100), 1, 0, 0, 0);
    check_out();

    // Full-chain wrap
    clear = 1;               step("t2_clr",   16'h0000, 16'h0000, 0, 0, 0, 0);
    load = 1; load_val = 16'h9599;
                             step("t2_load",  16'h9599, 16'h9599, 0, 0, 0, 0);
    start_stop = 1;          step("t2_start", 16'h9599, 16'h9599, 1, 0, 0, 0);
    tick = 1;                step("t2_wrap",  16'h0000, 16'h0000, 1, 0, 1, 0);
                             step("t2_after", 16'h0000, 16'h0000, 1, 0, 0, 0);

    // Down count to zero -> EXPIRED
    clear = 1;               step("t3_clr",   16'h0000, 16'h0000, 0, 0, 0, 0);
    load = 1; load_val = 16'h0002; mode = 1;
                             step("t3_load",  16'h0002, 16'h0002, 0, 0, 0, 0);
    start_stop = 1;          step("t3_start", 16'h0002, 16'h0002, 1, 0, 0, 0);
    tick = 1;                step("t3_tick1", 16'h0001, 16'h0001, 1, 0, 0, 0);
    tick = 1;                step("t3_tick2", 16'h0000, 16'h0000, 0, 0, 0, 1);
                             step("t3_after", 16'h0000, 16'h0000, 0, 0, 0, 0);
    tick = 1; start_stop = 1;
                             step("t3_expired", 16'h0000, 16'h0000, 0, 0, 0, 0);

    // Lap freeze
    clear = 1; mode = 0;     step("t4_clr",   16'h0000, 16'h0000, 0, 0, 0, 0);
    load = 1; load_val = 16'h0009;
                             step("t4_load",  16'h0009, 16'h0009, 0, 0, 0, 0);
    start_stop = 1;          step("t4_start", 16'h0009, 16'h0009, 1, 0, 0, 0);
    lap = 1;                 step("t4_lap",   16'h0009, 16'h0009, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick = 1;
      cyc();
    end
    push_exp("t4_frozen", chain_of(21), 16'h0009, 1, 1, 0, 0);
    check_out();
    lap = 1;                 step("t4_unlap", 16'h0021, 16'h0021, 1, 0, 0, 0);

    // Saturating load, load beats tick
    clear = 1;               step("t5_clr",   16'h0000, 16'h0000, 0, 0, 0, 0);
    load = 1; load_val = 16'hFFFF;
                             step("t5_sat",   16'h9599, 16'h9599, 0, 0, 0, 0);
    start_stop = 1;          step("t5_start", 16'h9599, 16'h9599, 1, 0, 0, 0);
    load = 1; load_val = 16'h0003; tick = 1;
                             step("t5_ldtick", 16'h0003, 16'h0003, 1, 0, 0, 0);
                             step("t5_after",  16'h0003, 16'h0003, 1, 0, 0, 0);

    // Clear beats everything, including a frozen display
    lap = 1;                 step("t6_lap",   16'h0003, 16'h0003, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick = 1;
      cyc();
    end
    push_exp("t6_frozen", 16'h0006, 16'h0003, 1, 1, 0, 0);
    check_out();
    clear = 1; load = 1; load_val = 16'h1234; tick = 1; lap = 1; start_stop = 1;
                             step("t6_clear", 16'h0000, 16'h0000, 0, 0, 0, 0);

    // Down count started at zero: immediate done, no underflow
    mode = 1; start_stop = 1;
                             step("t7_start", 16'h0000, 16'h0000, 1, 0, 0, 0);
    tick = 1;                step("t7_zero",  16'h0000, 16'h0000, 0, 0, 0, 1);
    load = 1; load_val = 16'h0005;
                             step("t7_reload", 16'h0005, 16'h0005, 0, 0, 0, 0);
    start_stop = 1;          step("t7_restart", 16'h0005, 16'h0005, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
